tdm_demux: RTL and testbench

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux_if.sv | 29 ++
 rtl/tdm_demux.sv | 89 ++++++++
 tb/tb_tdm_demux.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// TDM demultiplexer bus: serial input stream plus recovered channel/frame outputs.
// master = stream source / result sink, slave = demultiplexer.
interface tdm_demux_if #(
    parameter int NCH = 4,
    parameter int W   = 8
);
    localparam int SW = $clog2(NCH);

    logic             din;
    logic             din_vld;
    logic             frame_sync;
    logic [W-1:0]     ch_data;
    logic [SW-1:0]    ch_sel;
    logic             ch_vld;
    logic [NCH*W-1:0] frame_data;
    logic             frame_vld;
    logic             frame_err;
    logic             busy;

    modport master (
        output din, din_vld, frame_sync,
        input  ch_data, ch_sel, ch_vld, frame_data, frame_vld, frame_err, busy
    );

    modport slave (
        input  din, din_vld, frame_sync,
        output ch_data, ch_sel, ch_vld, frame_data, frame_vld, frame_err, busy
    );
endinterface

// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer: clk, reset (async, active-high), bus (slave).
// Shifts MSB-first channel words, pulses ch_vld per word and frame_vld per frame.
module tdm_demux #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    tdm_demux_if.slave  bus
);
    localparam int SW = $clog2(NCH);
    localparam int BW = $clog2(W);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    logic [0:0]       state;
    logic [BW-1:0]    bit_cnt;
    logic [SW-1:0]    ch_cnt;
    logic [W-1:0]     word;
    logic [NCH*W-1:0] slots;

    logic [W-1:0]     word_nxt;
    logic [NCH*W-1:0] frame_nxt;
    logic             last_bit;
    logic             last_ch;

    assign word_nxt = {word[W-2:0], bus.din};
    assign last_bit = (bit_cnt == BW'(W - 1));
    assign last_ch  = (ch_cnt == SW'(NCH - 1));
    assign bus.busy = (state == S_RECV);

    // Slot image with the word being completed merged in; becomes
    // frame_data only when the last channel finishes.
    always_comb begin
        frame_nxt = slots;
        frame_nxt[ch_cnt*W +: W] = word_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            bit_cnt        <= '0;
            ch_cnt         <= '0;
            word           <= '0;
            slots          <= '0;
            bus.ch_data    <= '0;
            bus.ch_sel     <= '0;
            bus.ch_vld     <= 1'b0;
            bus.frame_data <= '0;
            bus.frame_vld  <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.ch_vld    <= 1'b0;
            bus.frame_vld <= 1'b0;
            bus.frame_err <= 1'b0;
            if (bus.din_vld) begin
                if (bus.frame_sync) begin
                    // Sync inside RECV aborts the partial frame; the
                    // sync bit always starts a fresh frame as ch0 MSB.
                    bus.frame_err <= (state == S_RECV);
                    state         <= S_RECV;
                    word          <= {{(W-1){1'b0}}, bus.din};
                    bit_cnt       <= BW'(1);
                    ch_cnt        <= '0;
                end else if (state == S_RECV) begin
                    word <= word_nxt;
                    if (last_bit) begin
                        bit_cnt     <= '0;
                        bus.ch_data <= word_nxt;
                        bus.ch_sel  <= ch_cnt;
                        bus.ch_vld  <= 1'b1;
                        slots       <= frame_nxt;
                        if (last_ch) begin
                            bus.frame_data <= frame_nxt;
                            bus.frame_vld  <= 1'b1;
                            state          <= S_IDLE;
                            ch_cnt         <= '0;
                        end else begin
                            ch_cnt <= ch_cnt + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux (NCH=4, W=8): directed frames, stalls, aborts,
// back-to-back frames, mid-frame reset and idle noise against a frame model.
module tb_tdm_demux;
    localparam int NCH = 4;
    localparam int W   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    tdm_demux_if #(.NCH(NCH), .W(W)) bus ();

    tdm_demux #(.NCH(NCH), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Frame model: position within frame (-1 = waiting for sync).
    int         m_pos = -1;
    logic [7:0] m_word;
    logic [7:0] m_slot [NCH];
    logic [7:0] m_ch_data;
    logic [1:0] m_ch_sel;
    logic       m_ch_vld, m_fv, m_err;
    logic [31:0] m_frame;

    // Pulse monitor
    int         n_ch, n_fv, n_err;
    int         ch_cyc[$];
    int         fv_cyc[$];
    logic [7:0] ch_dq[$];
    logic [1:0] ch_sq[$];

    always @(posedge clk) begin
        logic b, s, v;
        int   c;
        cyc++;
        b = bus.din;
        s = bus.frame_sync;
        v = bus.din_vld;
        m_ch_vld = 1'b0;
        m_fv     = 1'b0;
        m_err    = 1'b0;
        if (reset) begin
            m_pos     = -1;
            m_ch_data = '0;
            m_ch_sel  = '0;
            m_frame   = '0;
            for (int k = 0; k < NCH; k++) m_slot[k] = '0;
        end else if (v) begin
            if (s) begin
                if (m_pos >= 0) m_err = 1'b1;
                m_pos = 0;
            end
            if (m_pos >= 0) begin
                m_word = (m_word << 1) | 8'(b);
                m_pos++;
                if (m_pos % W == 0) begin
                    c = m_pos / W - 1;
                    m_slot[c] = m_word;
                    m_ch_data = m_word;
                    m_ch_sel  = 2'(c);
                    m_ch_vld  = 1'b1;
                    if (c == NCH - 1) begin
                        for (int k = 0; k < NCH; k++)
                            m_frame[k*W +: W] = m_slot[k];
                        m_fv  = 1'b1;
                        m_pos = -1;
                    end
                end
            end
        end
        #1;
        chk("ch_vld", 64'(bus.ch_vld), 64'(m_ch_vld));
        chk("frame_vld", 64'(bus.frame_vld), 64'(m_fv));
        chk("frame_err", 64'(bus.frame_err), 64'(m_err));
        chk("busy", 64'(bus.busy), 64'(m_pos >= 0));
        chk("ch_data", 64'(bus.ch_data), 64'(m_ch_data));
        chk("ch_sel", 64'(bus.ch_sel), 64'(m_ch_sel));
        chk("frame_data", 64'(bus.frame_data), 64'(m_frame));
        if (bus.ch_vld) begin
            n_ch++;
            ch_cyc.push_back(cyc);
            ch_dq.push_back(bus.ch_data);
            ch_sq.push_back(bus.ch_sel);
        end
        if (bus.frame_vld) begin
            n_fv++;
            fv_cyc.push_back(cyc);
        end
        if (bus.frame_err) n_err++;
    end

    task automatic clr();
        n_ch = 0;
        n_fv = 0;
        n_err = 0;
        ch_cyc.delete();
        fv_cyc.delete();
        ch_dq.delete();
        ch_sq.delete();
    endtask

    task automatic drive(input logic b, input logic s, input logic v);
        bus.din        = b;
        bus.frame_sync = s;
        bus.din_vld    = v;
        @(negedge clk);
    endtask

    // Sends the first nbits of frame f; gap inserts a stall after each bit.
    int last_cyc;
    task automatic send_bits(input logic [31:0] f, input int nbits,
                             input bit gap);
        logic [31:0] fv;
        int n;
        fv = f;
        n = 0;
        for (int c = 0; c < NCH; c++) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (n < nbits) begin
                    drive(fv[c*W + i], n == 0, 1'b1);
                    last_cyc = cyc;
                    if (gap) drive(1'b0, 1'b0, 1'b0);
                end
                n++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.din = 1'b0;
        bus.frame_sync = 1'b0;
        bus.din_vld = 1'b0;
        clr();
        repeat (2) @(negedge clk);
        chk("rst_ch_data", 64'(bus.ch_data), 64'h0);
        chk("rst_frame_data", 64'(bus.frame_data), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        reset = 1'b0;
        idle(2);

        // Continuous frame
        clr();
        send_bits(32'h01FF3CA5, 32, 1'b0);
        idle(2);
        chk("t1_nch", 64'(n_ch), 64'd4);
        chk("t1_nfv", 64'(n_fv), 64'd1);
        if (ch_dq.size() == 4 && fv_cyc.size() == 1) begin
            chk("t1_w0", 64'(ch_dq[0]), 64'hA5);
            chk("t1_w1", 64'(ch_dq[1]), 64'h3C);
            chk("t1_w2", 64'(ch_dq[2]), 64'hFF);
            chk("t1_w3", 64'(ch_dq[3]), 64'h01);
            chk("t1_sel3", 64'(ch_sq[3]), 64'd3);
            chk("t1_space", 64'(ch_cyc[1] - ch_cyc[0]), 64'd8);
            chk("t1_fv_lat", 64'(fv_cyc[0]), 64'(last_cyc));
            chk("t1_fv_ch", 64'(fv_cyc[0]), 64'(ch_cyc[3]));
        end
        chk("t1_frame", 64'(bus.frame_data), 64'h01FF3CA5);

        // Same frame with din_vld low every other cycle
        clr();
        send_bits(32'h01FF3CA5, 32, 1'b1);
        idle(2);
        chk("t2_nch", 64'(n_ch), 64'd4);
        chk("t2_nfv", 64'(n_fv), 64'd1);
        if (ch_cyc.size() == 4) begin
            chk("t2_space", 64'(ch_cyc[2] - ch_cyc[1]), 64'd16);
            chk("t2_w2", 64'(ch_dq[2]), 64'hFF);
        end
        chk("t2_frame", 64'(bus.frame_data), 64'h01FF3CA5);

        // Sync reasserted at bit 13
        clr();
        send_bits(32'hCAFEF00D, 13, 1'b0);
        send_bits(32'h11223344, 32, 1'b0);
        idle(2);
        chk("t3_nerr", 64'(n_err), 64'd1);
        chk("t3_nch", 64'(n_ch), 64'd5);
        chk("t3_nfv", 64'(n_fv), 64'd1);
        if (ch_dq.size() == 5) begin
            chk("t3_abort_w0", 64'(ch_dq[0]), 64'h0D);
            chk("t3_new_w0", 64'(ch_dq[1]), 64'h44);
        end
        chk("t3_frame", 64'(bus.frame_data), 64'h11223344);

        // Back-to-back frames
        clr();
        send_bits(32'h89ABCDEF, 32, 1'b0);
        send_bits(32'h76543210, 32, 1'b0);
        idle(2);
        chk("t4_nfv", 64'(n_fv), 64'd2);
        chk("t4_nerr", 64'(n_err), 64'd0);
        if (fv_cyc.size() == 2)
            chk("t4_space", 64'(fv_cyc[1] - fv_cyc[0]), 64'd32);
        chk("t4_frame", 64'(bus.frame_data), 64'h76543210);

        // Reset at bit 20
        send_bits(32'hDEADBEEF, 20, 1'b0);
        reset = 1'b1;
        #1;
        chk("t5_ch_data", 64'(bus.ch_data), 64'h0);
        chk("t5_ch_sel", 64'(bus.ch_sel), 64'h0);
        chk("t5_frame", 64'(bus.frame_data), 64'h0);
        chk("t5_busy", 64'(bus.busy), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        clr();
        for (int i = 0; i < 10; i++) drive(1'(i % 3 == 0), 1'b0, 1'b1);
        chk("t5_nosync_busy", 64'(bus.busy), 64'h0);
        chk("t5_nosync_nch", 64'(n_ch), 64'd0);
        send_bits(32'hDEADBEEF, 32, 1'b0);
        idle(2);
        chk("t5_frame2", 64'(bus.frame_data), 64'hDEADBEEF);
        chk("t5_nfv", 64'(n_fv), 64'd1);

        // Idle noise, no sync
        clr();
        for (int i = 0; i < 50; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        idle(2);
        chk("t6_nch", 64'(n_ch), 64'd0);
        chk("t6_nfv", 64'(n_fv), 64'd0);
        chk("t6_nerr", 64'(n_err), 64'd0);
        chk("t6_busy", 64'(bus.busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
